slow_stable_capture: RTL and testbench

- Slow-domain consumer placed directly downstream of the fast-to-slow synchronizer.
- The synchronizer's N-bit bus can be momentarily incoherent across bits after crossing, so this block accepts a value only once it has held for STABLE_CYCLES consecutive slowclk samples.
- Each newly qualified value that differs from the last committed value is presented on a one-deep valid/ready output register.
- A sticky overflow flag records any value lost to back-pressure.

---
 rtl/slow_stable_capture.sv | 141 ++++++++++++++
 tb/tb_slow_stable_capture.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/slow_stable_capture.sv
`default_nettype none
// ============================================================================
// Module   : slow_stable_capture
// Brief    : Stability filter and one-deep valid/ready output register for a
//            bus arriving from a fast-to-slow synchronizer.
// Option   : SLOW_STABLE_CAPTURE_TS_EN adds a free-running commit timestamp.
// Revision : 1.0
// ============================================================================
module slow_stable_capture #(
   parameter int             N             = 2,
   parameter int             STABLE_CYCLES = 2,
   parameter logic [N-1:0]   RESET_VAL     = '0,
   parameter int             TS_W          = 16
) (
   input  logic             slowclk,
   input  logic             rst_n,
   input  logic [N-1:0]     synced,
   output logic [N-1:0]     out_data,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic             ovf_clr,
   output logic             overflow
`ifdef SLOW_STABLE_CAPTURE_TS_EN
   ,output logic [TS_W-1:0] out_ts
`endif
);

   localparam int                c_CNT_W   = $clog2(STABLE_CYCLES + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STABLE_CYCLES);

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   if (STABLE_CYCLES < 1 || TS_W < 1 || N < 1) begin : g_param_check
      $error("slow_stable_capture: illegal parameter value");
   end

   logic [N-1:0]       r_s_q;
   logic [c_CNT_W-1:0] r_cnt;
   logic [N-1:0]       r_committed;
   logic [N-1:0]       r_data;
   logic               r_ovf;
   state_t             r_state;

   logic               w_qual;
   state_t             w_state_nxt;
   logic               w_ovf_nxt;

   // Sample register and run-length counter; the counter saturates so a
   // long-held value stays qualified without wrapping.
   always_ff @(posedge slowclk or negedge rst_n) begin
      if (!rst_n) begin
         r_s_q <= RESET_VAL;
         r_cnt <= c_CNT_MAX;
      end else begin
         r_s_q <= synced;
         if (synced != r_s_q) begin
            r_cnt <= c_CNT_W'(1);
         end else if (r_cnt != c_CNT_MAX) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
         end
      end
   end

   assign w_qual = (r_cnt == c_CNT_MAX) && (r_s_q != r_committed);

   always_ff @(posedge slowclk or negedge rst_n) begin
      if (!rst_n) begin
         r_committed <= RESET_VAL;
         r_data      <= RESET_VAL;
      end else if (w_qual) begin
         r_committed <= r_s_q;
         r_data      <= r_s_q;
      end
   end

   always_ff @(posedge slowclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ovf   <= w_ovf_nxt;
      end
   end

   // A qualifying value while FULL always replaces the held one; it is only
   // a loss when the consumer did not take the old value on the same edge.
   always_comb begin
      w_state_nxt = r_state;
      w_ovf_nxt   = r_ovf;
      if (ovf_clr) begin
         w_ovf_nxt = 1'b0;
      end
      case (r_state)
         ST_EMPTY: begin
            if (w_qual) begin
               w_state_nxt = ST_FULL;
            end
         end
         ST_FULL: begin
            if (out_ready && !w_qual) begin
               w_state_nxt = ST_EMPTY;
            end else if (!out_ready && w_qual) begin
               w_ovf_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_EMPTY;
         end
      endcase
   end

   assign out_data  = r_data;
   assign out_valid = (r_state == ST_FULL);
   assign overflow  = r_ovf;

`ifdef SLOW_STABLE_CAPTURE_TS_EN
   logic [TS_W-1:0] r_ts_cnt;
   logic [TS_W-1:0] r_ts;

   // The stamp is the counter value before this edge's increment.
   always_ff @(posedge slowclk or negedge rst_n) begin
      if (!rst_n) begin
         r_ts_cnt <= '0;
         r_ts     <= '0;
      end else begin
         r_ts_cnt <= r_ts_cnt + TS_W'(1);
         if (w_qual) begin
            r_ts <= r_ts_cnt;
         end
      end
   end

   assign out_ts = r_ts;
`endif

endmodule
`default_nettype wire

// File: tb/tb_slow_stable_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_slow_stable_capture
// Brief    : Directed self-checking bench with a queue of expected commits.
// Revision : 1.0
// ============================================================================
module tb_slow_stable_capture;

   localparam int N = 2;

   logic         slowclk = 1'b0;
   logic         rst_n;
   logic [N-1:0] synced;
   logic [N-1:0] out_data;
   logic         out_valid;
   logic         out_ready;
   logic         ovf_clr;
   logic         overflow;
`ifdef SLOW_STABLE_CAPTURE_TS_EN
   logic [3:0]   out_ts;
`endif

   int vectors = 0;
   int errors  = 0;
   logic [N-1:0] exp_q[$];

   slow_stable_capture #(
      .N(N), .STABLE_CYCLES(2), .RESET_VAL(2'b00), .TS_W(4)
   ) dut (
      .slowclk  (slowclk),
      .rst_n    (rst_n),
      .synced   (synced),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .ovf_clr  (ovf_clr),
      .overflow (overflow)
`ifdef SLOW_STABLE_CAPTURE_TS_EN
      ,.out_ts  (out_ts)
`endif
   );

   always #5 slowclk = ~slowclk;

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge slowclk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pops the oldest expected commit and compares it with the presented data.
   task automatic check_commit(input string tag);
      logic [N-1:0] e;
      if (exp_q.size() == 0) begin
         check({tag, "_queue_empty"}, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_valid"}, 32'(out_valid), 32'd1);
         check({tag, "_data"}, 32'(out_data), 32'(e));
      end
   endtask

   initial begin
      rst_n = 1'b0; synced = 2'b00; out_ready = 1'b0; ovf_clr = 1'b0;
      tick(2);
      check("reset_valid", 32'(out_valid), 32'd0);
      check("reset_ovf", 32'(overflow), 32'd0);
      rst_n = 1'b1;

      // Steady reset value never produces an event.
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_valid", 32'(out_valid), 32'd0);
      end
      check("idle_data", 32'(out_data), 32'd0);
      check("idle_ovf", 32'(overflow), 32'd0);

      // out_ready while EMPTY is ignored.
      out_ready = 1'b1;
      tick();
      check("empty_ready_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b0;

      // Single-sample glitch, then back to committed value.
      synced = 2'b01;
      tick();
      synced = 2'b00;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("glitch_valid", 32'(out_valid), 32'd0);
      end
      check("glitch_data", 32'(out_data), 32'd0);

      // Latency: first sampled at e0, valid after e2.
      synced = 2'b11;
      exp_q.push_back(2'b11);
      tick(2);
      check("latency_early", 32'(out_valid), 32'd0);
      tick();
      check_commit("commit11");
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("accept_valid", 32'(out_valid), 32'd0);
      tick(3);
      check("no_recommit", 32'(out_valid), 32'd0);

      // Reset mid-operation with a pending value discards it immediately.
      synced = 2'b01;
      exp_q.push_back(2'b01);
      tick(3);
      check_commit("commit01");
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_valid", 32'(out_valid), 32'd0);
      check("async_rst_data", 32'(out_data), 32'd0);
      synced = 2'b00;
      tick();
      rst_n = 1'b1;

      // Back-pressure overwrite sets overflow; clear leaves the value pending.
      synced = 2'b11;
      exp_q.push_back(2'b11);
      tick(3);
      check_commit("bp_commit11");
      synced = 2'b10;
      exp_q.push_back(2'b10);
      tick(2);
      check("bp_ovf_before", 32'(overflow), 32'd0);
      check("bp_data_before", 32'(out_data), 32'd3);
      tick();
      check_commit("bp_commit10");
      check("bp_ovf_set", 32'(overflow), 32'd1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("ovf_clr", 32'(overflow), 32'd0);
      check("ovf_clr_valid", 32'(out_valid), 32'd1);
      check("ovf_clr_data", 32'(out_data), 32'd2);

      // Set and clear on the same edge: set wins.
      synced = 2'b01;
      exp_q.push_back(2'b01);
      tick(2);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check_commit("setclr_commit");
      check("setclr_ovf", 32'(overflow), 32'd1);
      ovf_clr = 1'b1;
      out_ready = 1'b1;
      tick();
      ovf_clr = 1'b0;
      out_ready = 1'b0;
      check("drain_valid", 32'(out_valid), 32'd0);
      check("drain_ovf", 32'(overflow), 32'd0);

      // Accept on the same edge a new value qualifies: replace, no overflow.
      synced = 2'b11;
      exp_q.push_back(2'b11);
      tick(3);
      check_commit("race_commit11");
      synced = 2'b10;
      exp_q.push_back(2'b10);
      tick(2);
      out_ready = 1'b1;
      tick();
      check_commit("race_commit10");
      check("race_ovf", 32'(overflow), 32'd0);
      tick();
      out_ready = 1'b0;
      check("race_drained", 32'(out_valid), 32'd0);

      // Reset between commit and acceptance.
      synced = 2'b11;
      exp_q.push_back(2'b11);
      tick(3);
      check_commit("pre_rst_commit");
      #2 rst_n = 1'b0;
      #1;
      check("rst_pending_valid", 32'(out_valid), 32'd0);
      check("rst_pending_data", 32'(out_data), 32'd0);
      synced = 2'b00;
      tick();
      rst_n = 1'b1;

      // Commit on the 17th edge after reset release.
      tick(14);
      check("pre_ts_valid", 32'(out_valid), 32'd0);
      synced = 2'b01;
      exp_q.push_back(2'b01);
      tick(3);
      check_commit("ts_commit");
`ifdef SLOW_STABLE_CAPTURE_TS_EN
      check("ts_wrap", 32'(out_ts), 32'd0);
`endif

      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire
